// File: rtl/hdmi_cfg_pkg.sv
// Shared types and the fixed ADV7513 register table for the HDMI TX configuration sequencer.
package hdmi_cfg_pkg;

  localparam int CFG_LEN = 12;

  typedef struct packed {
    logic [7:0] regaddr;
    logic [7:0] val;
  } cfg_entry_t;

  // The last entry clears the transmitter's interrupt sources, so a hot-plug line deasserts.
  localparam cfg_entry_t CFG_TABLE [CFG_LEN] = '{
    '{regaddr: 8'h41, val: 8'h10},
    '{regaddr: 8'h98, val: 8'h03},
    '{regaddr: 8'h9A, val: 8'hE0},
    '{regaddr: 8'h9C, val: 8'h30},
    '{regaddr: 8'h9D, val: 8'h61},
    '{regaddr: 8'hA2, val: 8'hA4},
    '{regaddr: 8'hA3, val: 8'hA4},
    '{regaddr: 8'hE0, val: 8'hD0},
    '{regaddr: 8'hF9, val: 8'h00},
    '{regaddr: 8'h15, val: 8'h00},
    '{regaddr: 8'h16, val: 8'h30},
    '{regaddr: 8'h96, val: 8'hFF}
  };

  typedef enum logic [2:0] {
    StPwrup,
    StLoad,
    StXfer,
    StNext,
    StIdle
  } cfg_state_e;

  function automatic cfg_entry_t cfg_lookup(input logic [4:0] idx);
    cfg_entry_t e;
    e = '0;
    for (int i = 0; i < CFG_LEN; i++) begin
      if (idx == 5'(i)) e = CFG_TABLE[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/hdmi_i2c_write_engine.sv
// Fixed-length I2C register write (START, dev/reg/val bytes with ACK slots, STOP) plus the
// quarter-tick divider. A NACK skips straight to STOP and is reported alongside done.
module hdmi_i2c_write_engine #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned I2C_HZ = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [6:0] i_dev,
  input  logic [7:0] i_reg,
  input  logic [7:0] i_val,
  input  logic       i_sda,
  output logic       o_tick,
  output logic       o_done,
  output logic       o_nack,
  output logic       o_scl,
  output logic       o_sda_oe
);

  localparam int unsigned QDIV_RAW = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned QDIV     = (QDIV_RAW == 0) ? 1 : QDIV_RAW;
  localparam logic [6:0]  LAST_Q   = 7'd123;
  localparam logic [6:0]  STOP_Q   = 7'd116;

  logic [31:0] r_div;
  logic        r_busy, r_done, r_nack, r_scl, r_sda;
  logic [6:0]  r_q;
  logic [26:0] r_frame;
  logic        w_tick, w_ack_slot;
  logic [6:0]  w_q_next;

  // Bit periods: 0 idle, 1 START, 2..28 data/ACK, 29..30 STOP. Returns {scl, sda}.
  function automatic logic [1:0] f_bus(input logic [6:0] q, input logic [26:0] frame);
    logic [4:0] b;
    logic [1:0] p;
    logic [1:0] lv;
    b = q[6:2];
    p = q[1:0];
    if (b == 5'd0)       lv = 2'b11;
    else if (b == 5'd1)  lv = {p != 2'd3, p == 2'd0};
    else if (b <= 5'd28) lv = {(p == 2'd1) || (p == 2'd2), frame[5'd28 - b]};
    else if (b == 5'd29) lv = {p != 2'd0, 1'b0};
    else                 lv = 2'b11;
    return lv;
  endfunction

  assign w_tick     = (r_div == QDIV - 1);
  assign w_ack_slot = (r_q[6:2] == 5'd10) || (r_q[6:2] == 5'd19) || (r_q[6:2] == 5'd28);

  always_comb begin
    w_q_next = r_q + 7'd1;
    if (r_nack && (r_q[1:0] == 2'd3) && (r_q < STOP_Q)) w_q_next = STOP_Q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nack  <= 1'b0;
      r_q     <= '0;
      r_frame <= '0;
      r_scl   <= 1'b1;
      r_sda   <= 1'b1;
    end else begin
      r_done <= 1'b0;
      r_div  <= (w_tick || (i_start && !r_busy)) ? '0 : r_div + 32'd1;
      if (!r_busy) begin
        if (i_start) begin
          r_busy       <= 1'b1;
          r_nack       <= 1'b0;
          r_q          <= '0;
          r_frame      <= {i_dev, 1'b0, 1'b1, i_reg, 1'b1, i_val, 1'b1};
          {r_scl, r_sda} <= 2'b11;
        end
      end else if (w_tick) begin
        if (w_ack_slot && (r_q[1:0] == 2'd2) && i_sda) r_nack <= 1'b1;
        if (r_q == LAST_Q) begin
          r_busy         <= 1'b0;
          r_done         <= 1'b1;
          {r_scl, r_sda} <= 2'b11;
        end else begin
          r_q            <= w_q_next;
          {r_scl, r_sda} <= f_bus(w_q_next, r_frame);
        end
      end
    end
  end

  assign o_tick   = w_tick;
  assign o_done   = r_done;
  assign o_nack   = r_nack;
  assign o_scl    = r_scl;
  assign o_sda_oe = ~r_sda;

endmodule

// File: rtl/hdmi_tx_cfg_sequencer.sv
// ADV7513 init sequencer: power-up delay, table walk with NACK retries, done/error status.
// HDMI_CFG_HPD_REINIT_EN enables re-running the table on a sustained low hdmi_tx_int_n.
module hdmi_tx_cfg_sequencer #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned I2C_HZ    = 100000,
  parameter logic [6:0]  DEV_ADDR  = 7'h39,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned PWRUP_CYC = 10000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cfg_start,
  input  logic       hdmi_tx_int_n,
  output logic       i2c_scl,
  output logic       i2c_sda_oe,
  input  logic       i2c_sda_in,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [4:0] cfg_index
);

  import hdmi_cfg_pkg::*;

  cfg_state_e  r_state;
  logic [31:0] r_pwr;
  logic [7:0]  r_retry;
  logic        r_busy, r_done, r_err;
  logic [4:0]  r_index;
  logic        r_sda_m, r_sda_s;
  logic        w_tick, w_eng_done, w_eng_nack, w_eng_start, w_hpd, w_restart;
  cfg_entry_t  w_entry;

  assign w_entry     = cfg_lookup(r_index);
  assign w_eng_start = (r_state == StLoad);
  assign w_restart   = cfg_start | w_hpd;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_sda_m <= 1'b1;
      r_sda_s <= 1'b1;
    end else begin
      r_sda_m <= i2c_sda_in;
      r_sda_s <= r_sda_m;
    end
  end

`ifdef HDMI_CFG_HPD_REINIT_EN
  logic       r_int_m, r_int_s;
  logic [3:0] r_int_cnt;

  // Counts consecutive low quarter-ticks while idle; the 16th one triggers a restart.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_int_m   <= 1'b1;
      r_int_s   <= 1'b1;
      r_int_cnt <= '0;
    end else begin
      r_int_m <= hdmi_tx_int_n;
      r_int_s <= r_int_m;
      if ((r_state != StIdle) || r_int_s) r_int_cnt <= '0;
      else if (w_tick && (r_int_cnt != 4'd15)) r_int_cnt <= r_int_cnt + 4'd1;
    end
  end

  assign w_hpd = (r_state == StIdle) && !r_int_s && w_tick && (r_int_cnt == 4'd15);
`else
  logic w_unused_int;
  assign w_unused_int = hdmi_tx_int_n ^ w_tick;
  assign w_hpd        = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state <= StPwrup;
      r_pwr   <= '0;
      r_retry <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_index <= '0;
    end else begin
      unique case (r_state)
        StPwrup: begin
          r_busy <= 1'b1;
          if (r_pwr == PWRUP_CYC - 1) begin
            r_retry <= '0;
            r_state <= StLoad;
          end else begin
            r_pwr <= r_pwr + 32'd1;
          end
        end
        StLoad: r_state <= StXfer;
        StXfer: begin
          if (w_eng_done) begin
            if (!w_eng_nack) begin
              r_state <= StNext;
            end else if (r_retry < 8'(RETRY_MAX)) begin
              r_retry <= r_retry + 8'd1;
              r_state <= StLoad;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end
        end
        StNext: begin
          if (r_index == 5'(CFG_LEN - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_index <= r_index + 5'd1;
            r_retry <= '0;
            r_state <= StLoad;
          end
        end
        StIdle: begin
          if (w_restart) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_index <= '0;
            r_retry <= '0;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  hdmi_i2c_write_engine #(
    .CLK_HZ (CLK_HZ),
    .I2C_HZ (I2C_HZ)
  ) u_engine (
    .i_clk    (clk_clk),
    .i_rst_n  (reset_reset_n),
    .i_start  (w_eng_start),
    .i_dev    (DEV_ADDR),
    .i_reg    (w_entry.regaddr),
    .i_val    (w_entry.val),
    .i_sda    (r_sda_s),
    .o_tick   (w_tick),
    .o_done   (w_eng_done),
    .o_nack   (w_eng_nack),
    .o_scl    (i2c_scl),
    .o_sda_oe (i2c_sda_oe)
  );

  assign cfg_busy  = r_busy;
  assign cfg_done  = r_done;
  assign cfg_error = r_err;
  assign cfg_index = r_index;

endmodule
